// File: rtl/rob_pkg.sv
// Shared types and default sizing for the reorder buffer.
package rob_pkg;

  typedef enum logic [1:0] {
    ROB_ALU = 2'd0,
    ROB_LD  = 2'd1,
    ROB_ST  = 2'd2,
    ROB_BR  = 2'd3
  } rob_op_t;

  localparam int ROB_DEPTH     = 8;
  localparam int ROB_CDB_PORTS = 2;

endpackage

// File: rtl/rob_param.sv
// Reorder buffer: in-order alloc, out-of-order CDB completion, in-order retire,
// single-cycle full flush when a mispredicted branch retires.
module rob_param
  import rob_pkg::*;
#(
  parameter int DEPTH     = ROB_DEPTH,
  parameter int CDB_PORTS = ROB_CDB_PORTS,
  parameter int XLEN      = 32,
  parameter int PTR_W     = $clog2(DEPTH)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                alloc_valid,
  output logic                                alloc_ready,
  input  rob_op_t                             alloc_op,
  input  logic [4:0]                          alloc_rd,
  input  logic [XLEN-1:0]                     alloc_pc,
  output logic [PTR_W-1:0]                    alloc_tag,
  input  logic [CDB_PORTS-1:0]                cdb_valid,
  input  logic [CDB_PORTS-1:0][PTR_W-1:0]     cdb_tag,
  input  logic [CDB_PORTS-1:0][XLEN-1:0]      cdb_value,
  input  logic [CDB_PORTS-1:0]                cdb_mispredict,
  input  logic [CDB_PORTS-1:0][XLEN-1:0]      cdb_target,
  output logic                                commit_valid,
  input  logic                                commit_ready,
  output logic [PTR_W-1:0]                    commit_tag,
  output rob_op_t                             commit_op,
  output logic [4:0]                          commit_rd,
  output logic [XLEN-1:0]                     commit_value,
  output logic                                commit_rf_we,
  output logic                                flush,
  output logic [XLEN-1:0]                     flush_pc,
  output logic [DEPTH-1:0]                    live_mask,
  output logic [PTR_W:0]                      count
);

  localparam int SEL_W = (CDB_PORTS > 1) ? $clog2(CDB_PORTS) : 1;

  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             flush_q, flush_d;
  logic [XLEN-1:0]  flush_pc_q, flush_pc_d;
  logic [DEPTH-1:0] alloc_q, alloc_d, done_q, done_d, misp_q, misp_d;

  rob_op_t          op_q     [DEPTH];
  logic [4:0]       rd_q     [DEPTH];
  logic [XLEN-1:0]  pc_q     [DEPTH];
  logic [XLEN-1:0]  value_q  [DEPTH];
  logic [XLEN-1:0]  target_q [DEPTH];

  logic                              alloc_fire, commit_fire;
  logic [CDB_PORTS-1:0][DEPTH-1:0]   port_mask;
  logic [DEPTH-1:0]                  cdb_we;
  logic [SEL_W-1:0]                  cdb_sel [DEPTH];

  assign alloc_ready  = (count_q < (PTR_W+1)'(DEPTH)) & ~flush_q;
  assign alloc_fire   = alloc_valid & alloc_ready;
  assign alloc_tag    = tail_q;

  assign commit_valid = alloc_q[head_q] & done_q[head_q] & ~flush_q;
  assign commit_fire  = commit_valid & commit_ready;
  assign commit_tag   = head_q;
  assign commit_op    = op_q[head_q];
  assign commit_rd    = rd_q[head_q];
  assign commit_value = value_q[head_q];
  assign commit_rf_we = commit_valid & ((op_q[head_q] == ROB_ALU) | (op_q[head_q] == ROB_LD))
                        & (rd_q[head_q] != 5'd0);

  assign flush     = flush_q;
  assign flush_pc  = flush_pc_q;
  assign live_mask = alloc_q;
  assign count     = count_q;

  // Each port decodes its tag into an entry mask; writes to dead entries and
  // anything arriving during the flush cycle are dropped here.
  for (genvar p = 0; p < CDB_PORTS; p++) begin : g_cdb
    logic hit;
    assign hit          = cdb_valid[p] & alloc_q[cdb_tag[p]] & ~flush_q;
    assign port_mask[p] = hit ? (DEPTH'(1) << cdb_tag[p]) : '0;
  end

  // Scan high-to-low so the lowest-numbered port wins a shared tag.
  always_comb begin
    cdb_we = '0;
    for (int e = 0; e < DEPTH; e++) begin
      cdb_sel[e] = '0;
      for (int p = CDB_PORTS - 1; p >= 0; p--) begin
        if (port_mask[p][e]) begin
          cdb_we[e]  = 1'b1;
          cdb_sel[e] = SEL_W'(p);
        end
      end
    end
  end

  always_comb begin
    alloc_d    = alloc_q;
    done_d     = done_q;
    misp_d     = misp_q;
    head_d     = head_q;
    tail_d     = tail_q;
    flush_d    = 1'b0;
    flush_pc_d = flush_pc_q;
    count_d    = count_q + (PTR_W+1)'(alloc_fire) - (PTR_W+1)'(commit_fire);

    for (int e = 0; e < DEPTH; e++) begin
      if (cdb_we[e]) begin
        done_d[e] = 1'b1;
        misp_d[e] = cdb_mispredict[cdb_sel[e]] & (op_q[e] == ROB_BR);
      end
    end

    if (alloc_fire) begin
      alloc_d[tail_q] = 1'b1;
      done_d[tail_q]  = 1'b0;
      misp_d[tail_q]  = 1'b0;
      tail_d          = tail_q + PTR_W'(1);
    end

    if (commit_fire) begin
      alloc_d[head_q] = 1'b0;
      done_d[head_q]  = 1'b0;
      head_d          = head_q + PTR_W'(1);
      if (misp_q[head_q]) begin
        flush_d    = 1'b1;
        flush_pc_d = target_q[head_q];
        alloc_d    = '0;
        done_d     = '0;
        misp_d     = '0;
        tail_d     = head_q + PTR_W'(1);
        count_d    = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      flush_q    <= 1'b0;
      flush_pc_q <= '0;
      alloc_q    <= '0;
      done_q     <= '0;
      misp_q     <= '0;
      for (int e = 0; e < DEPTH; e++) begin
        op_q[e]     <= ROB_ALU;
        rd_q[e]     <= '0;
        pc_q[e]     <= '0;
        value_q[e]  <= '0;
        target_q[e] <= '0;
      end
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      flush_q    <= flush_d;
      flush_pc_q <= flush_pc_d;
      alloc_q    <= alloc_d;
      done_q     <= done_d;
      misp_q     <= misp_d;
      if (alloc_fire) begin
        op_q[tail_q] <= alloc_op;
        rd_q[tail_q] <= alloc_rd;
        pc_q[tail_q] <= alloc_pc;
      end
      for (int e = 0; e < DEPTH; e++) begin
        if (cdb_we[e]) begin
          value_q[e]  <= cdb_value[cdb_sel[e]];
          target_q[e] <= cdb_target[cdb_sel[e]];
        end
      end
    end
  end

endmodule

// File: doc/rob_param.md
# rob_param

Parametrised reorder buffer for the Tomasulo core. It allocates entries in program order from the instruction queue and captures results from several CDB ports, out of order. It retires one completed entry per cycle from the head towards the register file and LSQ. A mispredicted branch at the head triggers a single-cycle full flush with a redirect PC, which replaces the multi-cycle flush walk of the previous ROB.

## Interface
Parameters:
- DEPTH, 8: number of entries; power of two, ≥ 4.
- CDB_PORTS, 2: number of result broadcast ports.
- XLEN, 32: data and PC width.
- PTR_W, $clog2(DEPTH): tag width; derived, not overridden.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- alloc_valid  in  1  IQ requests an entry.
- alloc_ready  out  1  entry available.
- alloc_op  in  rob_op_t  ALU/LD/ST/BR class.
- alloc_rd  in  5  destination register, or store source register for ST.
- alloc_pc  in  XLEN  instruction PC.
- alloc_tag  out  PTR_W  tag granted (current tail).
- cdb_valid  in  CDB_PORTS  per-port result strobe.
- cdb_tag  in  CDB_PORTS×PTR_W  entry being completed.
- cdb_value  in  CDB_PORTS×XLEN  result.
- cdb_mispredict  in  CDB_PORTS  branch resolved opposite to its prediction.
- cdb_target  in  CDB_PORTS×XLEN  correct next PC for the branch.
- commit_valid  out  1  head entry is retiring.
- commit_ready  in  1  consumer accepts; held low by the LSQ until d-cache response for ST/LD.
- commit_tag, commit_op, commit_rd, commit_value  out  (PTR_W, rob_op_t, 5, XLEN)  retiring entry fields.
- commit_rf_we  out  1  commit_valid & op is ALU or LD & rd≠0.
- flush  out  1  registered one-cycle pulse.
- flush_pc  out  XLEN  redirect target.
- live_mask  out  DEPTH  allocated-entry bitmap, used by RS/LSQ to squash.
- count  out  PTR_W+1  occupancy.

## Operation
- Per-entry state: alloc bit, done bit, mispredict bit, op, rd, pc, value, target.
- Head, tail and count are registers. Full means count==DEPTH; empty means count==0. Head and tail wrap modulo DEPTH naturally.
- alloc_ready = (count<DEPTH) & ~flush. On alloc_valid&alloc_ready:
  - write the entry at tail, set alloc, clear done and mispredict;
  - tail+1;
  - alloc_tag is valid combinationally the same cycle.
- CDB port p with cdb_valid[p]:
  - if alloc[cdb_tag] is set, write value, mispredict and target, and set done;
  - writes to unallocated tags are ignored;
  - if two ports hit the same tag in one cycle, the lower port index wins.
- commit_valid = alloc[head] & done[head] & ~flush. On commit_valid&commit_ready, clear alloc[head] and done[head], then head+1.
- A commit with mispredict[head] set causes the following in the next cycle:
  - flush=1 and flush_pc=target of that branch;
  - all alloc and done bits cleared;
  - tail set to the committed head+1 (equal to the new head), count=0.
- In the same cycle as a count update, count = count + alloc − commit. Clearing on flush has priority over both.

## Timing
- Reset: head=tail=0, count=0, all alloc/done bits 0, flush=0, flush_pc=0, commit_valid=0, alloc_ready=1, live_mask=0.
- A CDB write becomes visible to commit one cycle later; there is no CDB→commit bypass. Minimum alloc→commit latency is 2 cycles.
- When full, alloc is refused even if a commit happens the same cycle; alloc_ready depends only on the registered count.
- Flush cycle:
  - alloc_ready=0 and commit_valid=0;
  - CDB writes are dropped;
  - alloc resumes the following cycle.
- Non-branch ops never set mispredict; cdb_mispredict on them is ignored.
- rst asserted during a flush or mid-commit overrides everything and returns all state to reset values next cycle.

## Structure
- rob_pkg holds rob_op_t {ROB_ALU, ROB_LD, ROB_ST, ROB_BR} and the default DEPTH/CDB_PORTS constants.
- No sub-module: entry arrays plus head/tail/count logic live in one module. CDB capture is a generate loop over ports.

## Test plan
- Reset, then allocate 8 ALU ops, DEPTH=8 → tags 0..7, count=8, alloc_ready=0; 9th alloc_valid ignored.
- Complete tags 3,1,0,2 via CDB ports 0/1 → commits retire 0,1,2,3 in order, one per cycle, commit_rf_we=1 each.
- Tag 0 is ST, commit_ready low 5 cycles → commit_valid held, head stays 0, then retires on ready.
- BR at tag 2 completes with mispredict=1, target=0x80000040, tags 3–5 live → after tag 2 commits, flush=1 one cycle, flush_pc=0x80000040, count=0, live_mask=0, next alloc_tag=3.
- Wrap: 20 alloc/commit pairs → tags cycle 0..7, count never exceeds 8, no lost entries.
- Both CDB ports write tag 4 in one cycle with values 0x11/0x22 → commit_value=0x11.
